// File: rtl/pmod_dac_wave_gen_pkg.sv
// Shared types and constants for the PModDAC waveform generator.
package pmod_dac_wave_gen_pkg;

    localparam int PHASE_W = 16;

    localparam logic [7:0] DAC_MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_e;

    // Doubling happens in PHASE_W+1 bits so an overflowing doubled value still compares above the ceiling.
    function automatic logic [PHASE_W-1:0] next_tune(
        input logic [PHASE_W-1:0] tune,
        input logic [PHASE_W-1:0] dflt,
        input logic [PHASE_W-1:0] ceil_v
    );
        logic [PHASE_W:0]   dbl;
        logic [PHASE_W-1:0] result;
        dbl = {tune, 1'b0};
        if (dbl > {1'b0, ceil_v}) begin
            result = dflt;
        end else begin
            result = dbl[PHASE_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/pmod_dac_wave_gen_sine_lut.sv
// Quarter-wave sine ROM: 6-bit index -> 7-bit amplitude, round(127*sin((i+0.5)*pi/128)).
module pmod_dac_wave_gen_sine_lut (
    input  logic [5:0] i_idx,
    output logic [6:0] o_amp
);

    always_comb begin
        case (i_idx)
            6'd0:  o_amp = 7'd2;
            6'd1:  o_amp = 7'd5;
            6'd2:  o_amp = 7'd8;
            6'd3:  o_amp = 7'd11;
            6'd4:  o_amp = 7'd14;
            6'd5:  o_amp = 7'd17;
            6'd6:  o_amp = 7'd20;
            6'd7:  o_amp = 7'd23;
            6'd8:  o_amp = 7'd26;
            6'd9:  o_amp = 7'd29;
            6'd10: o_amp = 7'd32;
            6'd11: o_amp = 7'd35;
            6'd12: o_amp = 7'd38;
            6'd13: o_amp = 7'd41;
            6'd14: o_amp = 7'd44;
            6'd15: o_amp = 7'd47;
            6'd16: o_amp = 7'd50;
            6'd17: o_amp = 7'd53;
            6'd18: o_amp = 7'd56;
            6'd19: o_amp = 7'd58;
            6'd20: o_amp = 7'd61;
            6'd21: o_amp = 7'd64;
            6'd22: o_amp = 7'd67;
            6'd23: o_amp = 7'd69;
            6'd24: o_amp = 7'd72;
            6'd25: o_amp = 7'd74;
            6'd26: o_amp = 7'd77;
            6'd27: o_amp = 7'd79;
            6'd28: o_amp = 7'd82;
            6'd29: o_amp = 7'd84;
            6'd30: o_amp = 7'd86;
            6'd31: o_amp = 7'd89;
            6'd32: o_amp = 7'd91;
            6'd33: o_amp = 7'd93;
            6'd34: o_amp = 7'd95;
            6'd35: o_amp = 7'd97;
            6'd36: o_amp = 7'd99;
            6'd37: o_amp = 7'd101;
            6'd38: o_amp = 7'd103;
            6'd39: o_amp = 7'd105;
            6'd40: o_amp = 7'd106;
            6'd41: o_amp = 7'd108;
            6'd42: o_amp = 7'd110;
            6'd43: o_amp = 7'd111;
            6'd44: o_amp = 7'd113;
            6'd45: o_amp = 7'd114;
            6'd46: o_amp = 7'd115;
            6'd47: o_amp = 7'd117;
            6'd48: o_amp = 7'd118;
            6'd49: o_amp = 7'd119;
            6'd50: o_amp = 7'd120;
            6'd51: o_amp = 7'd121;
            6'd52: o_amp = 7'd122;
            6'd53: o_amp = 7'd123;
            6'd54: o_amp = 7'd124;
            6'd55: o_amp = 7'd124;
            6'd56: o_amp = 7'd125;
            6'd57: o_amp = 7'd125;
            6'd58: o_amp = 7'd126;
            6'd59: o_amp = 7'd126;
            6'd60: o_amp = 7'd127;
            6'd61: o_amp = 7'd127;
            6'd62: o_amp = 7'd127;
            6'd63: o_amp = 7'd127;
            default: o_amp = 7'd0;
        endcase
    end

endmodule

// File: rtl/pmod_dac_wave_gen.sv
// Sample-rate waveform generator feeding PModDAC: phase accumulator, shaper and switch-driven settings.
module pmod_dac_wave_gen
    import pmod_dac_wave_gen_pkg::*;
#(
    parameter int                 SAMPLE_DIV   = 250,
    parameter logic [PHASE_W-1:0] DEFAULT_TUNE = 16'd655,
    parameter logic [PHASE_W-1:0] MAX_TUNE     = 16'd16384
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Wave_Next,
    input  logic               i_Freq_Next,
    output logic [7:0]         o_Byte,
    output logic               o_Sample_Tick,
    output logic [1:0]         o_Wave_Sel,
    output logic [PHASE_W-1:0] o_Tune
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] tune_q, tune_d;
    logic [PHASE_W-1:0] tune_act_q, tune_act_d;
    wave_e              wave_sel_q, wave_sel_d;
    wave_e              wave_act_q, wave_act_d;
    logic               wave_prev_q, wave_prev_d;
    logic               freq_prev_q, freq_prev_d;
    logic               tick_dly_q, tick_dly_d;
    logic [7:0]         byte_q, byte_d;
    logic               sample_tick_q, sample_tick_d;

    logic               tick_s;
    logic               wave_rise_s;
    logic               freq_rise_s;
    logic [5:0]         sine_idx_s;
    logic [6:0]         sine_amp_s;
    logic [7:0]         shape_s;

    // Sample timer and phase accumulator; pending settings are latched only on the tick.
    always_comb begin
        tick_s     = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        tick_dly_d = tick_s;
        phase_d    = phase_q;
        wave_act_d = wave_act_q;
        tune_act_d = tune_act_q;
        if (tick_s) begin
            cnt_d      = {CNT_W{1'b0}};
            phase_d    = phase_q + tune_act_q;
            wave_act_d = wave_sel_q;
            tune_act_d = tune_q;
        end else begin
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    // Switch edge detection and pending waveform / tuning-word stepping.
    always_comb begin
        wave_rise_s = i_Wave_Next & ~wave_prev_q;
        freq_rise_s = i_Freq_Next & ~freq_prev_q;
        wave_prev_d = i_Wave_Next;
        freq_prev_d = i_Freq_Next;
        if (wave_rise_s) begin
            wave_sel_d = wave_e'(2'(wave_sel_q + 2'd1));
        end else begin
            wave_sel_d = wave_sel_q;
        end
        if (freq_rise_s) begin
            tune_d = next_tune(tune_q, DEFAULT_TUNE, MAX_TUNE);
        end else begin
            tune_d = tune_q;
        end
    end

    // Sine folds the four quadrants onto one quarter-wave table.
    assign sine_idx_s = phase_q[14] ? ~phase_q[13:8] : phase_q[13:8];

    pmod_dac_wave_gen_sine_lut u_sine_lut (
        .i_idx (sine_idx_s),
        .o_amp (sine_amp_s)
    );

    // Waveform shaper from the active phase and waveform.
    always_comb begin
        shape_s = DAC_MIDSCALE;
        case (wave_act_q)
            WAVE_SQUARE: shape_s = phase_q[15] ? 8'hFF : 8'h00;
            WAVE_SAW:    shape_s = phase_q[15:8];
            WAVE_TRI:    shape_s = phase_q[15] ? ~phase_q[14:7] : phase_q[14:7];
            WAVE_SINE:   shape_s = phase_q[15] ? (8'd127 - {1'b0, sine_amp_s})
                                               : (8'd128 + {1'b0, sine_amp_s});
            default:     shape_s = DAC_MIDSCALE;
        endcase
    end

    // Output register loads one cycle after the tick, from the freshly advanced phase.
    always_comb begin
        sample_tick_d = tick_dly_q;
        if (tick_dly_q) begin
            byte_d = shape_s;
        end else begin
            byte_d = byte_q;
        end
    end

    // State registers; switch history resets high so a held switch gives no edge at release.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q         <= {CNT_W{1'b0}};
            phase_q       <= {PHASE_W{1'b0}};
            tune_q        <= DEFAULT_TUNE;
            tune_act_q    <= DEFAULT_TUNE;
            wave_sel_q    <= WAVE_SQUARE;
            wave_act_q    <= WAVE_SQUARE;
            wave_prev_q   <= 1'b1;
            freq_prev_q   <= 1'b1;
            tick_dly_q    <= 1'b0;
            byte_q        <= DAC_MIDSCALE;
            sample_tick_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            tune_q        <= tune_d;
            tune_act_q    <= tune_act_d;
            wave_sel_q    <= wave_sel_d;
            wave_act_q    <= wave_act_d;
            wave_prev_q   <= wave_prev_d;
            freq_prev_q   <= freq_prev_d;
            tick_dly_q    <= tick_dly_d;
            byte_q        <= byte_d;
            sample_tick_q <= sample_tick_d;
        end
    end

    assign o_Byte        = byte_q;
    assign o_Sample_Tick = sample_tick_q;
    assign o_Wave_Sel    = wave_sel_q;
    assign o_Tune        = tune_q;

endmodule
